// File: rtl/s_to_p_deser.sv
// Serial-to-parallel deserializer: MSB-first bits qualified by din_valid are packed into W-bit
// words and handed to a one-entry valid/ready output buffer, with overrun and gap-timeout flags.
module s_to_p_deser #(
   parameter int unsigned W       = 4,
   parameter int unsigned TIMEOUT = 8,
   localparam int unsigned CntW   = (W > 1) ? $clog2(W) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            din,
   input  logic            din_valid,
   output logic [W-1:0]    dout,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic            overrun,
   input  logic            ovf_clr,
   output logic            frame_err,
   output logic [CntW-1:0] bit_cnt
);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [W-1:0]    sreg_q, sreg_d;
   logic [7:0]      gap_q, gap_d;
   logic [W-1:0]    dout_q, dout_d;
   logic            dout_valid_q, dout_valid_d;
   logic            overrun_q, overrun_d;
   logic            frame_err_q, frame_err_d;

   logic [W-1:0]    word;
   logic            complete;
   logic            accept;
   logic            drop;

   assign word   = {sreg_q[W-2:0], din};
   assign accept = dout_valid_q & dout_ready;

   // Shift register, bit counter and gap timer.
   always_comb begin
      sreg_d      = sreg_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      complete    = 1'b0;
      frame_err_d = 1'b0;
      if (din_valid) begin
         sreg_d = word;
         gap_d  = '0;
         if (cnt_q == CntW'(W - 1)) begin
            complete = 1'b1;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end else if ((state_q == StShift) && (TIMEOUT != 0)) begin
         if (({1'b0, gap_q} + 9'd1) == 9'(TIMEOUT)) begin
            // Partial word abandoned; the output buffer is left untouched.
            sreg_d      = '0;
            cnt_d       = '0;
            gap_d       = '0;
            frame_err_d = 1'b1;
         end else begin
            gap_d = gap_q + 8'd1;
         end
      end else begin
         gap_d = '0;
      end
      state_d = (cnt_d != '0) ? StShift : StIdle;
   end

   // One-entry output buffer and sticky overrun.
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      drop         = complete & dout_valid_q & ~dout_ready;
      if (complete && !drop) begin
         dout_d       = word;
         dout_valid_d = 1'b1;
      end else if (accept && !complete) begin
         dout_valid_d = 1'b0;
      end
      if (drop) begin
         overrun_d = 1'b1;
      end else if (ovf_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         sreg_q       <= '0;
         gap_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sreg_q       <= sreg_d;
         gap_q        <= gap_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign overrun    = overrun_q;
   assign frame_err  = frame_err_q;
   assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_s_to_p_deser.sv
// Self-checking bench for s_to_p_deser: directed sequences, a vector table and a randomized run
// compared against a word-level reference model.
module tb_s_to_p_deser;

   localparam int unsigned W       = 4;
   localparam int unsigned TIMEOUT = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         din;
   logic         din_valid;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         overrun;
   logic         ovf_clr;
   logic         frame_err;
   logic [1:0]   bit_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] word;
      logic       ready;
      logic [3:0] exp_dout;
      logic       exp_valid;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[7];

   s_to_p_deser #(
      .W       (W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .overrun    (overrun),
      .ovf_clr    (ovf_clr),
      .frame_err  (frame_err),
      .bit_cnt    (bit_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_bit(input logic b);
      din       = b;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] w);
      for (int i = 3; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) step();
      rst = 1'b1;
   endtask

   // Reference model state (word-level view of the deserializer).
   int         m_val, m_len, m_idle;
   logic [3:0] m_dout;
   logic       m_valid, m_ovr, m_ferr;

   task automatic model_reset();
      m_val = 0; m_len = 0; m_idle = 0;
      m_dout = 4'h0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
   endtask

   task automatic model_edge(input logic r, input logic dv, input logic d, input logic rdy,
                             input logic clr);
      logic       done, lost;
      logic [3:0] w;
      if (!r) begin
         model_reset();
         return;
      end
      done   = 1'b0;
      w      = 4'h0;
      m_ferr = 1'b0;
      if (dv) begin
         m_val  = (m_val * 2 + int'(d)) % 16;
         m_len  = m_len + 1;
         m_idle = 0;
         if (m_len == W) begin
            done  = 1'b1;
            w     = 4'(m_val);
            m_len = 0;
         end
      end else if (m_len > 0) begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            m_len = 0; m_val = 0; m_idle = 0; m_ferr = 1'b1;
         end
      end
      lost = done && m_valid && !rdy;
      if (done && !lost) begin
         m_dout  = w;
         m_valid = 1'b1;
      end else if (!done && m_valid && rdy) begin
         m_valid = 1'b0;
      end
      if (lost) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
   endtask

   initial begin
      rst = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b1; ovf_clr = 1'b0;

      // Reset state
      do_reset();
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_cnt", bit_cnt, 0);

      // Single word 1010
      send_word(4'b1010);
      chk("w1_dout", dout, 4'b1010);
      chk("w1_valid", dout_valid, 1);
      chk("w1_ovr", overrun, 0);
      chk("w1_ferr", frame_err, 0);
      step();
      chk("w1_drop_valid", dout_valid, 0);
      chk("w1_hold_dout", dout, 4'b1010);

      // Back-to-back words 1010, 1111
      for (int i = 0; i < 8; i++) begin
         send_bit((i < 4) ? ((i % 2) == 0) : 1'b1);
         if (i == 3) begin
            chk("b2b_first", dout, 4'b1010);
            chk("b2b_first_v", dout_valid, 1);
         end
         if (i == 4) chk("b2b_gap_v", dout_valid, 0);
         if (i == 7) begin
            chk("b2b_second", dout, 4'b1111);
            chk("b2b_second_v", dout_valid, 1);
         end
      end
      step();
      chk("b2b_done_v", dout_valid, 0);

      // Overrun under backpressure
      dout_ready = 1'b0;
      send_word(4'b0010);
      chk("ovr_first", dout, 4'b0010);
      send_word(4'b1111);
      chk("ovr_hold", dout, 4'b0010);
      chk("ovr_valid", dout_valid, 1);
      chk("ovr_set", overrun, 1);
      dout_ready = 1'b1;
      step();
      chk("ovr_accept_v", dout_valid, 0);
      chk("ovr_sticky", overrun, 1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovr_clr", overrun, 0);

      // Completion and accept on the same edge
      dout_ready = 1'b0;
      send_word(4'b1010);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      chk("same_hold", dout, 4'b1010);
      dout_ready = 1'b1;
      send_bit(1'b1);
      chk("same_dout", dout, 4'b0101);
      chk("same_valid", dout_valid, 1);
      chk("same_ovr", overrun, 0);
      step();

      // Set beats clear on the same edge
      dout_ready = 1'b0;
      send_word(4'b0001);
      ovf_clr = 1'b1;
      send_word(4'b0011);
      ovf_clr = 1'b0;
      chk("prio_ovr", overrun, 1);
      dout_ready = 1'b1;
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;

      // Gap timeout
      send_bit(1'b1); send_bit(1'b1);
      chk("to_cnt2", bit_cnt, 2);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("to_no_err", frame_err, 0);
      end
      step();
      chk("to_ferr", frame_err, 1);
      chk("to_cnt0", bit_cnt, 0);
      step();
      chk("to_ferr_pulse", frame_err, 0);
      send_word(4'b0110);
      chk("to_next_word", dout, 4'b0110);
      chk("to_next_valid", dout_valid, 1);
      step();

      // Long idle while not mid-word raises nothing
      repeat (20) step();
      chk("idle_no_err", frame_err, 0);

      // Reset mid-word and with a buffered word
      send_bit(1'b1); send_bit(1'b0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("rmid_cnt", bit_cnt, 0);
      chk("rmid_valid", dout_valid, 0);
      dout_ready = 1'b0;
      send_word(4'b1100);
      chk("rbuf_pre", dout_valid, 1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("rbuf_dout", dout, 0);
      chk("rbuf_valid", dout_valid, 0);
      chk("rbuf_ovr", overrun, 0);
      dout_ready = 1'b1;
      send_word(4'b1001);
      chk("rbuf_next", dout, 4'b1001);

      // Vector table, starting from reset
      vecs[0] = '{4'h3, 1'b0, 4'h3, 1'b1, 1'b0};
      vecs[1] = '{4'hC, 1'b0, 4'h3, 1'b1, 1'b1};
      vecs[2] = '{4'h5, 1'b1, 4'h5, 1'b1, 1'b1};
      vecs[3] = '{4'hA, 1'b1, 4'hA, 1'b1, 1'b1};
      vecs[4] = '{4'h0, 1'b0, 4'hA, 1'b1, 1'b1};
      vecs[5] = '{4'hF, 1'b0, 4'hF, 1'b1, 1'b0};
      vecs[6] = '{4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         if (i == 5) begin
            dout_ready = 1'b1;
            ovf_clr    = 1'b1;
            step();
            ovf_clr    = 1'b0;
            chk("tbl_clr_v", dout_valid, 0);
            chk("tbl_clr_o", overrun, 0);
         end
         dout_ready = vecs[i].ready;
         send_word(vecs[i].word);
         chk($sformatf("tbl%0d_dout", i), dout, vecs[i].exp_dout);
         chk($sformatf("tbl%0d_valid", i), dout_valid, vecs[i].exp_valid);
         chk($sformatf("tbl%0d_ovr", i), overrun, vecs[i].exp_ovr);
      end

      // Randomized run against the reference model
      do_reset();
      model_reset();
      begin
         int gap_left = 0;
         for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            if (gap_left > 0) begin
               din_valid = 1'b0;
               gap_left--;
            end else begin
               din_valid = ($urandom_range(0, 3) != 0);
               if ($urandom_range(0, 15) == 0) gap_left = $urandom_range(5, 11);
            end
            din        = 1'($urandom);
            dout_ready = ($urandom_range(0, 2) != 0);
            ovf_clr    = ($urandom_range(0, 19) == 0);
            step();
            model_edge(rst, din_valid, din, dout_ready, ovf_clr);
            chk("rnd_dout", dout, m_dout);
            chk("rnd_valid", dout_valid, m_valid);
            chk("rnd_ovr", overrun, m_ovr);
            chk("rnd_ferr", frame_err, m_ferr);
            chk("rnd_cnt", bit_cnt, m_len);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
